// File: rtl/rst_seq_pkg.sv
// Shared types and encodings for the ordered reset-release sequencer.
package rst_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_STRETCH = 2'd1,
    ST_SEQ     = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Reset-cause encodings reported on rst_cause.
  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_WDT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  // Elaboration-time helper for sizing the shared down-counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the
// second clock edge after rstn goes high.
module rst_sync_2ff (
  input  logic clk,
  input  logic rstn,
  output logic rstn_s
);

  logic meta;

  // Shift a constant 1 through two flops; rstn low clears both at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta   <= 1'b0;
      rstn_s <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make rstn_s take meta's previous
      // value, so this really is a two-stage chain and not one flop.
      meta   <= 1'b1;
      rstn_s <= meta;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Ordered reset-release sequencer: stretches reset, then releases each
// domain reset in turn with a programmable gap; restarts on watchdog or
// software request and records the cause of the last reset.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_RST = 4,
  parameter int DLY_W   = 8,
  parameter int STRETCH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wdt_rst,
  input  logic                     sw_rst_req,
  output logic                     sw_rst_ack,
  input  logic [NUM_RST*DLY_W-1:0] dly_cfg,
  output logic [NUM_RST-1:0]       rst_out_n,
  output logic                     seq_done,
  output logic [1:0]               rst_cause
);

  localparam int CNT_W    = max_int(DLY_W, $clog2(STRETCH));
  localparam int IDX_W    = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
  localparam int DLY_SLOTS = 2 ** IDX_W;

  localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_RST - 1);

  logic                 rstn_s;
  state_e               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_nxt;
  logic                 sw_armed;
  logic                 wdt_hit;
  logic                 sw_hit;
  logic [DLY_W-1:0]     dly_arr [DLY_SLOTS];

  rst_sync_2ff u_sync (
    .clk    (clk),
    .rstn   (rstn),
    .rstn_s (rstn_s)
  );

  // Unpack the gap fields; slots past NUM_RST are unreachable and read 0.
  for (genvar k = 0; k < DLY_SLOTS; k++) begin : g_dly
    if (k < NUM_RST) begin : g_used
      assign dly_arr[k] = dly_cfg[k*DLY_W +: DLY_W];
    end else begin : g_pad
      assign dly_arr[k] = '0;
    end
  end

  assign idx_nxt = idx + IDX_W'(1);

  // Trigger decode: watchdog restarts from any active state and beats a
  // software request in the same cycle, which then stays pending.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch can be inferred.
    wdt_hit = 1'b0;
    sw_hit  = 1'b0;
    if (state != ST_RESET) begin
      wdt_hit = wdt_rst;
    end
    if (state == ST_DONE && !wdt_rst) begin
      sw_hit = sw_rst_req && sw_armed;
    end
  end

  // Software request arming: one accepted request per high level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sw_armed <= 1'b1;
    end else if (sw_hit) begin
      sw_armed <= 1'b0;
    end else if (!sw_rst_req) begin
      sw_armed <= 1'b1;
    end
  end

  // Main sequencer: stretch, timed per-domain release, done, restart.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_RESET;
      cnt        <= '0;
      idx        <= '0;
      rst_out_n  <= '0;
      seq_done   <= 1'b0;
      sw_rst_ack <= 1'b0;
      rst_cause  <= CAUSE_POR;
    end else begin
      sw_rst_ack <= 1'b0;
      if (wdt_hit || sw_hit) begin
        state     <= ST_STRETCH;
        cnt       <= STRETCH_LD;
        idx       <= '0;
        rst_out_n <= '0;
        seq_done  <= 1'b0;
        rst_cause <= wdt_hit ? CAUSE_WDT : CAUSE_SW;
      end else begin
        case (state)
          ST_RESET: begin
            if (rstn_s) begin
              state <= ST_STRETCH;
              cnt   <= STRETCH_LD;
            end
          end
          ST_STRETCH: begin
            if (cnt == '0) begin
              state <= ST_SEQ;
              idx   <= '0;
              cnt   <= CNT_W'(dly_arr[0]);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_SEQ: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              rst_out_n[idx] <= 1'b1;
              if (idx == LAST_IDX) begin
                state      <= ST_DONE;
                seq_done   <= 1'b1;
                sw_rst_ack <= (rst_cause == CAUSE_SW);
              end else begin
                idx <= idx_nxt;
                cnt <= CNT_W'(dly_arr[idx_nxt]);
              end
            end
          end
          default: begin
            // ST_DONE: hold all outputs released until a trigger.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl (NUM_RST=3, STRETCH=4, d=(2,1,0)).
// Stimulus pushes every expected output change (edge number + value);
// a monitor pops one entry per observed change and compares both.
module tb_rst_seq_ctrl;

  localparam int NUM_RST = 3;
  localparam int DLY_W   = 8;
  localparam int STRETCH = 4;

  localparam logic [1:0] C_POR = 2'b00;
  localparam logic [1:0] C_WDT = 2'b01;
  localparam logic [1:0] C_SW  = 2'b10;

  typedef struct packed {
    logic [2:0] rn;
    logic       done;
    logic       ack;
    logic [1:0] cause;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t val;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rstn = 1'b1;
  logic                     wdt_rst = 1'b0;
  logic                     sw_rst_req = 1'b0;
  logic                     sw_rst_ack;
  logic [NUM_RST*DLY_W-1:0] dly_cfg;
  logic [NUM_RST-1:0]       rst_out_n;
  logic                     seq_done;
  logic [1:0]               rst_cause;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  obs_t cur;
  exp_t sb [$];

  rst_seq_ctrl #(
    .NUM_RST (NUM_RST),
    .DLY_W   (DLY_W),
    .STRETCH (STRETCH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wdt_rst    (wdt_rst),
    .sw_rst_req (sw_rst_req),
    .sw_rst_ack (sw_rst_ack),
    .dly_cfg    (dly_cfg),
    .rst_out_n  (rst_out_n),
    .seq_done   (seq_done),
    .rst_cause  (rst_cause)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number n settles, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t sample();
    return {rst_out_n, seq_done, sw_rst_ack, rst_cause};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue an expected output value at edge c, if it is a visible change.
  task automatic push(input int c, input obs_t v);
    if (v !== cur) begin
      sb.push_back('{cyc: c, val: v});
      cur = v;
    end
  endtask

  // Trigger accepted at edge t; output k released at t + STRETCH + sum(d_j+1).
  // n_rel limits how many releases are expected (sequence may be cut short).
  task automatic push_seq(input int t, input logic [1:0] cause,
                          input int d0, input int d1, input int d2, input int n_rel);
    obs_t v;
    int   r;
    v       = cur;
    v.rn    = '0;
    v.done  = 1'b0;
    v.ack   = 1'b0;
    v.cause = cause;
    push(t, v);
    r = t + STRETCH + d0 + 1;
    if (n_rel >= 1) begin
      v.rn[0] = 1'b1;
      push(r, v);
    end
    r = r + d1 + 1;
    if (n_rel >= 2) begin
      v.rn[1] = 1'b1;
      push(r, v);
    end
    r = r + d2 + 1;
    if (n_rel >= 3) begin
      v.rn[2] = 1'b1;
      v.done  = 1'b1;
      v.ack   = (cause == C_SW);
      push(r, v);
      if (v.ack) begin
        v.ack = 1'b0;
        push(r + 1, v);
      end
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every output change must match the head of the scoreboard.
  initial begin
    obs_t prev;
    obs_t now;
    exp_t e;
    wait (mon_en);
    prev = '0;
    forever begin
      @(posedge clk or negedge rstn);
      #1;
      now = sample();
      if (now !== prev) begin
        if (sb.size() == 0) begin
          check($sformatf("unexpected_change@%0d", cyc), 32'(now), 32'(prev));
        end else begin
          e = sb.pop_front();
          check($sformatf("edge_of_change_exp%0d", e.cyc), cyc, e.cyc);
          check($sformatf("value@%0d", e.cyc), 32'(now), 32'(e.val));
        end
        prev = now;
      end
    end
  end

  initial begin
    int t;
    dly_cfg = {8'd0, 8'd1, 8'd2};   // d0=2, d1=1, d2=0
    cur     = '0;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(sample()), 32'h0);
    mon_en = 1'b1;

    // POR: E0 = first edge with rstn high; releases at E9/E11/E12.
    @(negedge clk);
    rstn = 1'b1;
    t = cyc + 1;
    push_seq(t + 2, C_POR, 2, 1, 0, 3);
    wait_until(t + 16);

    // Software reset: releases T+7/T+9/T+10, ack after T+10; held req must not retrigger.
    sw_rst_req = 1'b1;
    t = cyc + 1;
    push_seq(t, C_SW, 2, 1, 0, 3);
    wait_until(t + 20);

    // Watchdog at T+8 during a software sequence: releases T+15/17/18, no ack.
    sw_rst_req = 1'b0;
    @(negedge clk);
    sw_rst_req = 1'b1;
    t = cyc + 1;
    push_seq(t, C_SW, 2, 1, 0, 1);
    wait_until(t + 7);
    wdt_rst = 1'b1;
    push_seq(t + 8, C_WDT, 2, 1, 0, 3);
    @(negedge clk);
    wdt_rst = 1'b0;
    wait_until(t + 8 + 16);

    // Simultaneous triggers: watchdog wins, pending software taken on first DONE cycle.
    sw_rst_req = 1'b0;
    @(negedge clk);
    wdt_rst    = 1'b1;
    sw_rst_req = 1'b1;
    t = cyc + 1;
    push_seq(t, C_WDT, 2, 1, 0, 3);
    push_seq(t + 11, C_SW, 2, 1, 0, 3);
    @(negedge clk);
    wdt_rst = 1'b0;
    wait_until(t + 11 + 14);
    sw_rst_req = 1'b0;
    @(negedge clk);

    // Asynchronous reset between edges during SEQ, then full POR timing again.
    wdt_rst = 1'b1;
    t = cyc + 1;
    push_seq(t, C_WDT, 2, 1, 0, 1);
    @(negedge clk);
    wdt_rst = 1'b0;
    wait_until(t + 8);
    #2;
    push(cyc, '0);
    rstn = 1'b0;
    #1;
    check("async_assert", 32'({rst_out_n, seq_done, rst_cause}), 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    t = cyc + 1;
    push_seq(t + 2, C_POR, 2, 1, 0, 3);
    wait_until(t + 16);

    // Zero gaps: releases at T+5/T+6/T+7.
    dly_cfg = '0;
    @(negedge clk);
    wdt_rst = 1'b1;
    t = cyc + 1;
    push_seq(t, C_WDT, 0, 0, 0, 3);
    @(negedge clk);
    wdt_rst = 1'b0;
    wait_until(t + 12);

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Ordered reset-release sequencer that sits downstream of the board-level reset input. It synchronizes the asynchronous `rstn`, stretches reset for a minimum pulse width, then releases `NUM_RST` per-domain active-low resets one at a time with programmable inter-release gaps. It also re-runs the sequence on watchdog and software reset requests and reports the cause of the last reset.

## Interface
- `NUM_RST`, 4: number of sequenced reset outputs (≥1).
- `DLY_W`, 8: width of each per-output delay field.
- `STRETCH`, 16: cycles all outputs stay asserted before sequencing starts (≥1).

- `clk`  in  1: clock.
- `rstn`  in  1: reset, asynchronous, active-low.
- `wdt_rst`  in  1: watchdog reset request, sampled each cycle, synchronous to `clk`.
- `sw_rst_req`  in  1: software reset request level, synchronous to `clk`.
- `sw_rst_ack`  out  1: one-cycle pulse when a software-initiated sequence completes.
- `dly_cfg`  in  NUM_RST*DLY_W: field k = gap value d_k for output k; quasi-static, sampled at load.
- `rst_out_n`  out  NUM_RST: sequenced active-low resets; bit 0 is released first.
- `seq_done`  out  1: high when all outputs are released.
- `rst_cause`  out  2: last reset cause: 00 POR/`rstn`, 01 watchdog, 10 software.

## Operation
- Internal 2-flop synchronizer: asynchronous assert on `rstn` low, synchronous release. Its output is `rstn_s`.
- `rstn` low clears everything asynchronously:
  - `rst_out_n` = 0
  - `seq_done` = 0
  - `sw_rst_ack` = 0
  - `rst_cause` = 00
  - state RESET
  - software request re-armed
- FSM states:
  - **RESET**: stay while `rstn_s`=0. On the first edge with `rstn_s`=1, go to STRETCH with cnt = STRETCH-1.
  - **STRETCH**: decrement cnt each cycle. When cnt==0, go to SEQ with idx=0 and cnt=d_0.
  - **SEQ**: if cnt!=0, decrement. If cnt==0, set `rst_out_n[idx]`=1. If idx==NUM_RST-1, go to DONE; otherwise idx++ and cnt=d_(idx+1).
  - **DONE**: `seq_done`=1 and all outputs stay released.
- Trigger events, checked in STRETCH, SEQ and DONE:
  - `wdt_rst`=1: all `rst_out_n`=0, `seq_done`=0, `rst_cause`=01, go to STRETCH with cnt = STRETCH-1. This restarts the sequence from any state.
  - Software request, only in DONE, when `sw_rst_req`=1 and armed: same actions with `rst_cause`=10, and clear armed. Armed is set again on any cycle with `sw_rst_req`=0.
  - `wdt_rst` wins over a software request in the same cycle. The software request stays pending while it is still high and armed.
  - A software request raised during a sequence is taken on the first DONE cycle. This happens after the ack of the running sequence, if that sequence was software-initiated.
- `sw_rst_ack` pulses for one cycle at the DONE-entry edge, only when `rst_cause`==10.
- `rst_cause` holds its value until the next trigger. Only `rstn` clears it to 00.
- d_k=0 is legal and gives a 1-cycle gap. The maximum per-step gap is 2^DLY_W cycles.

## Timing
- Take E0 as the first clk edge with `rstn` high. `rstn_s` rises after E1, and the FSM leaves RESET at E2.
- For a trigger accepted at edge T (E2 for POR), output k is released at edge T + STRETCH + Σ_{j≤k}(d_j+1).
- `seq_done`, and `sw_rst_ack` when the cause is software, rise at the same edge as the last output release.
- Trigger-to-assertion latency: `rst_out_n` is low immediately after edge T, so registered latency is 1 cycle. `rstn` asserts the outputs asynchronously, with 0 cycles latency.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Package `rst_seq_pkg`:
  - state enum (RESET, STRETCH, SEQ, DONE)
  - cause encodings `CAUSE_POR`=2'b00, `CAUSE_WDT`=2'b01, `CAUSE_SW`=2'b10
- Sub-module `rst_sync_2ff` holds the 2-flop `rstn` synchronizer. The FSM, counter, index and output registers live in `rst_seq_ctrl`.
- Counter width: max(DLY_W, $clog2(STRETCH)). Index width: $clog2(NUM_RST), minimum 1.

## Test plan
Parameters: NUM_RST=3, STRETCH=4, d=(2,1,0).
- **POR**: release `rstn` before E0 → `rst_out_n`[0]/[1]/[2] go high at E9/E11/E12; `seq_done` and `rst_cause`=00 at E12; no `sw_rst_ack`.
- **Software reset**: `sw_rst_req` held high, sampled in DONE at edge T → all outputs 0 after T; releases at T+7, T+9, T+10; `sw_rst_ack` is high for exactly the cycle after T+10; `rst_cause`=10. Keeping `req` high after the ack must not retrigger.
- **Watchdog mid-sequence**: `wdt_rst` pulse at T+8 during a software sequence → `rst_out_n`[0] back to 0; releases at T+15/17/18; `rst_cause`=01; no ack.
- **Simultaneous triggers**: `wdt_rst` and an armed `sw_rst_req` in the same DONE cycle → `rst_cause`=01. The software request is then taken on the next DONE, giving `rst_cause`=10 followed by an ack.
- **Asynchronous reset mid-sequence**: `rstn` pulsed low between clock edges during SEQ → all outputs 0 immediately, with no clock; on release, the full POR timing repeats.
- **d=(0,0,0)**: trigger at T → releases at T+5, T+6, T+7.
